// File: rtl/fetch_controller.sv
// fetch_controller: fetch PC sequencer with a one-entry skid buffer; FETCH_MISALIGN_TRAP_EN adds the fetch_fault trap
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_fault
`endif
);
  typedef enum logic [1:0] {FILL, RUN, HOLD} state_t;
  state_t state, state_nxt;
  logic [31:0] fetch_pc, pend_pc, skid_instr, skid_pc, tgt, nxt_instr, nxt_pc;
  logic pend_valid, skid_valid, advance, nxt_valid, fault, bad_tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt = redirect_target;
  assign bad_tgt = |redirect_target[1:0];
  assign fetch_fault = fault;
`else
  assign tgt = redirect_target & 32'hFFFF_FFFC;
  assign bad_tgt = 1'b0;
`endif
  assign advance = !stall || !instr_valid;
  assign imem_addr = fetch_pc;
  always_ff @(posedge clk)
    state <= !reset ? FILL : state_nxt;
  // leaving HOLD always has a skid entry to present, so it resumes streaming
  always_comb
    state_nxt = redirect_valid ? FILL : !advance ? HOLD : (state == HOLD || nxt_valid) ? RUN : FILL;
  always_comb begin
    nxt_valid = skid_valid || pend_valid;
    nxt_instr = skid_valid ? skid_instr : imem_rdata;
    nxt_pc    = skid_valid ? skid_pc : pend_pc;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_pc     <= 32'h0;
      skid_valid  <= 1'b0;
      skid_instr  <= 32'h0;
      skid_pc     <= 32'h0;
      instr_valid <= 1'b0;
      instr_out   <= 32'h0000_0013;
      pc_out      <= 32'h0;
      fault       <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc    <= tgt;
      pend_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      instr_valid <= 1'b0;
      fault       <= bad_tgt;
    end else if (!advance) begin
      if (pend_valid && !skid_valid) begin
        skid_valid <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc    <= pend_pc;
      end
      pend_valid <= 1'b0;
    end else begin
      instr_valid <= nxt_valid;
      if (nxt_valid) begin
        instr_out <= nxt_instr;
        pc_out    <= nxt_pc;
      end
      skid_valid <= 1'b0;
      pend_valid <= !fault;
      pend_pc    <= fetch_pc;
      if (!fault)
        fetch_pc <= fetch_pc + 32'd4;
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed table, corner sequences and a random stream model for fetch_controller
module tb_fetch_controller;
  logic clk = 1'b0, reset = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0, imem_addr, imem_rdata = 32'h0, instr_out, pc_out;
  logic instr_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_fault;
`endif
  logic [31:0] mem [64];
  int vectors = 0, miscompares = 0;

  fetch_controller dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= mem[imem_addr[7:2]];

  typedef struct {
    logic st; logic rd; logic [31:0] tg;
    logic ev; logic [31:0] epc; logic ca; logic [31:0] eaddr;
  } vec_t;
  vec_t tv [14];

  function automatic logic [31:0] mw(input logic [31:0] a);
    return mem[a[7:2]];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic rd, input logic [31:0] tg, input logic rs);
    @(posedge clk);
    #1;
    stall = st; redirect_valid = rd; redirect_target = tg; reset = rs;
    @(negedge clk);
    if (dut.skid_valid && dut.pend_valid) begin
      miscompares++;
      $display("FAIL invariant: skid_valid and pend_valid both 1");
    end
  endtask

  task automatic chk_out(input string nm, input logic [31:0] pc);
    chk({nm, "_valid"}, {31'b0, instr_valid}, 32'd1);
    chk({nm, "_pc"}, pc_out, pc);
    chk({nm, "_instr"}, instr_out, mw(pc));
  endtask

  initial begin
    logic st, rd, rs, p_rs, p_rd, p_valid;
    logic [31:0] tg, p_tg, exp_pc, fill_t;
    int age;
    for (int i = 0; i < 64; i++) mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h0000_0013;
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0020_0113;
    mem[2] = 32'h0020_81B3;
    mem[3] = 32'h4020_8233;
    tv[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h0};
    tv[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0};
    tv[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0};
    tv[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  1'b0, 32'h0};
    tv[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  1'b0, 32'h0};
    tv[5]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  1'b0, 32'h0};
    tv[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  1'b0, 32'h0};
    tv[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  1'b0, 32'h0};
    tv[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hC,  1'b0, 32'h0};
    tv[9]  = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h10, 1'b0, 32'h0};
    tv[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h20};
    tv[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0};
    tv[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h20, 1'b0, 32'h0};
    tv[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h24, 1'b0, 32'h0};

    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr_out, 32'h0000_0013);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
`endif

    for (int i = 0; i < 14; i++) begin
      cyc(tv[i].st, tv[i].rd, tv[i].tg, 1'b1);
      chk($sformatf("tv%0d_valid", i), {31'b0, instr_valid}, {31'b0, tv[i].ev});
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_pc", i), pc_out, tv[i].epc);
        chk($sformatf("tv%0d_instr", i), instr_out, mw(tv[i].epc));
      end
      if (tv[i].ca) chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].eaddr);
    end

    // redirect while stalled with the skid full
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk_out("rs_hold", 32'h28);
    cyc(1'b1, 1'b1, 32'h80, 1'b1);
    chk_out("rs_r", 32'h28);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rs_r1_valid", {31'b0, instr_valid}, 32'd0);
    chk("rs_r1_addr", imem_addr, 32'h80);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rs_r2_valid", {31'b0, instr_valid}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("rs_r3", 32'h80);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("rs_r4", 32'h84);

    // one-cycle reset mid-stream with the skid full
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk_out("mr_hold", 32'h88);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mr_valid", {31'b0, instr_valid}, 32'd0);
    chk("mr_addr", imem_addr, 32'h0);
    chk("mr_instr", instr_out, 32'h0000_0013);
    chk("mr_pc", pc_out, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mr_c1_valid", {31'b0, instr_valid}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("mr_c2", 32'h0);

    // misaligned redirect, then aligned redirect
    cyc(1'b0, 1'b1, 32'h22, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("ma_r1_valid", {31'b0, instr_valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("ma_r1_fault", {31'b0, fetch_fault}, 32'd1);
    chk("ma_r1_addr", imem_addr, 32'h22);
`else
    chk("ma_r1_addr", imem_addr, 32'h20);
`endif
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("ma_r2_valid", {31'b0, instr_valid}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("ma_r3_valid", {31'b0, instr_valid}, 32'd0);
    chk("ma_r3_fault", {31'b0, fetch_fault}, 32'd1);
`else
    chk_out("ma_r3", 32'h20);
`endif
    cyc(1'b0, 1'b1, 32'h40, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("al_r1_valid", {31'b0, instr_valid}, 32'd0);
    chk("al_r1_addr", imem_addr, 32'h40);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("al_r1_fault", {31'b0, fetch_fault}, 32'd0);
`endif
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("al_r2_valid", {31'b0, instr_valid}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("al_r3", 32'h40);

    // random phase: stream model = next unconsumed PC plus fill latency after each flush
    p_rs = 1'b1; p_rd = 1'b0; p_valid = 1'b0; p_tg = 32'h0;
    exp_pc = 32'h0; fill_t = 32'h0; age = -3;
    for (int n = 0; n < 3000; n++) begin
      rs = (n == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      st = ($urandom_range(0, 9) < 4);
      rd = ($urandom_range(0, 29) == 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      tg = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_00FC);
`else
      tg = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF7 : ($urandom & 32'h0000_00FF);
`endif
      cyc(st, rd, tg, rs);
      if (!p_rs) begin
        age = 0; fill_t = 32'h0; exp_pc = 32'h0;
        chk("rnd_rst_instr", instr_out, 32'h0000_0013);
        chk("rnd_rst_pc", pc_out, 32'h0);
      end else if (p_rd) begin
        age = 0; fill_t = {p_tg[31:2], 2'b00}; exp_pc = fill_t;
      end else if (age >= 0) begin
        age = (age == 2) ? -1 : age + 1;
      end
      if (age == 0) begin
        chk("rnd_fill_addr", imem_addr, fill_t);
        chk("rnd_fill0_valid", {31'b0, instr_valid}, 32'd0);
      end
      if (age == 1) chk("rnd_fill1_valid", {31'b0, instr_valid}, 32'd0);
      if (age == 2) chk("rnd_first_valid", {31'b0, instr_valid}, 32'd1);
      if (age == -1 && p_valid && p_rs && !p_rd) chk("rnd_nobubble", {31'b0, instr_valid}, 32'd1);
      if (age != -3 && instr_valid) begin
        chk("rnd_pc", pc_out, exp_pc);
        chk("rnd_instr", instr_out, mw(exp_pc));
      end
      if (instr_valid && !st && !rd && rs) exp_pc = exp_pc + 32'd4;
      p_rs = rs; p_rd = rd; p_tg = tg; p_valid = instr_valid;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer for the RV32IM pipeline. It owns the fetch PC and drives the word address into the synchronous-read instruction memory, which returns data one cycle later. It applies branch/jump redirects from EX and back-pressure from the IF/ID register. It delivers one registered instruction/PC pair per cycle and uses a one-entry skid buffer so no fetched word is lost or duplicated under stall.

## Interface
- RESET_PC, 32'h0000_0000, fetch address presented during and after reset
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; sampled on posedge clk
- stall  in  1  IF/ID cannot accept the current output this cycle
- redirect_valid  in  1  taken branch/jump from EX; has priority over stall
- redirect_target  in  32  new fetch PC
- imem_addr  out  32  byte PC to instruction memory (= fetch_pc register)
- imem_rdata  in  32  instruction memory data for the address presented last cycle
- instr_out  out  32  fetched instruction (registered)
- pc_out  out  32  PC of instr_out (registered)
- instr_valid  out  1  instr_out/pc_out hold a valid instruction
- fetch_fault  out  1  misaligned redirect; only present with FETCH_MISALIGN_TRAP_EN

## Operation
- Registers:
  - fetch_pc
  - pend_valid/pend_pc: request issued last cycle, data on imem_rdata now
  - skid_valid/skid_instr/skid_pc
  - output regs
  - 2-bit state
- Reset (reset==0 at edge):
  - fetch_pc=RESET_PC
  - pend_valid=0, skid_valid=0, instr_valid=0
  - instr_out=32'h0000_0013 (NOP), pc_out=0
  - fetch_fault=0
  - state=FILL
- advance = !stall || !instr_valid.
- Priority per cycle: reset > redirect > blocked (!advance) > advance.
- Redirect:
  - fetch_pc<=redirect_target
  - pend_valid<=0, skid_valid<=0, instr_valid<=0
  - state<=FILL
  - The wrong-path address issued this cycle is discarded.
- Blocked (stall && instr_valid):
  - Output regs and fetch_pc hold.
  - If pend_valid && !skid_valid: skid<=(imem_rdata,pend_pc).
  - pend_valid<=0 always; the held fetch_pc is re-issued on release.
  - state<=HOLD.
- Advance:
  - Output source is, in order: skid if skid_valid, else (imem_rdata,pend_pc) if pend_valid, else bubble (instr_valid<=0).
  - The skid is cleared when used.
  - Issue: pend<=(1,fetch_pc); fetch_pc<=fetch_pc+4.
  - state<=RUN if the output is valid, else FILL.
- Invariant (bench assertion): skid_valid implies !pend_valid.
- At most one skid entry is ever needed.
- fetch_pc arithmetic is 32-bit unsigned, +4 wraps 32'hFFFF_FFFC -> 0.
- imem_addr is a byte address; the memory indexes by addr/4.
- States:
  - FILL: pipeline empty after reset/redirect.
  - RUN: streaming.
  - HOLD: blocked by stall.
  - Transitions follow the rules above.
  - HOLD->RUN on !stall.
  - Any state->FILL on redirect.

## Timing
- Address-to-output latency is 2 cycles.
  - Address A presented in cycle N.
  - imem_rdata=mem[A] in N+1.
  - instr_out valid in N+2.
- After reset release (first cycle with reset==1 is cycle 0):
  - imem_addr=RESET_PC in cycle 0.
  - First instr_valid=1 with pc_out=RESET_PC in cycle 2.
- Redirect asserted in cycle R:
  - imem_addr=target in R+1.
  - instr_valid=0 in R+1 and R+2.
  - instr_valid=1, pc_out=target in R+3.
- Stall:
  - The output holds for every cycle stall is high while instr_valid=1.
  - On the first cycle stall is low, the output is consumed and the next output (skid) appears one cycle later.
  - No gap in sequence and no duplicate.
- Redirect in the same cycle as stall: redirect wins and the held output is dropped.
- Reset mid-operation: all state is discarded at that edge, with the reset values above.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with target[1:0]!=0 sets fetch_fault=1, which is sticky until reset or the next aligned redirect.
  - fetch_pc still loads the target, but no issue occurs (pend_valid stays 0).
  - instr_valid stays 0 until cleared.
- Undefined:
  - The fetch_fault port is absent.
  - redirect_target[1:0] is forced to 2'b00.

## Test plan
- Reset release, mem[0..3]=ADDI/ADDI/ADD/SUB, no stall -> instr_valid rises cycle 2, pc_out 0,4,8,12 on consecutive cycles with matching instr_out.
- Stall high 3 cycles while pc_out=4 -> pc_out/instr_out hold 4 for 3 cycles; after release outputs 8, 12 with no skip/duplicate; skid used once.
- Redirect to 0x20 in cycle R while streaming -> instr_valid 0 in R+1, R+2; pc_out=0x20 in R+3, then 0x24.
- Redirect and stall in the same cycle, skid full -> skid and output flushed; pc_out=target at R+3.
- Reset low for one cycle mid-stream with skid full -> next cycle instr_valid=0, imem_addr=RESET_PC, instr_out=0x00000013.
- FETCH_MISALIGN_TRAP_EN: redirect to 0x22 -> fetch_fault=1, instr_valid stays 0; redirect to 0x40 -> fetch_fault=0, pc_out=0x40 three cycles later.
